dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port data RAM between the pipeline memory stage (CPU port) and a loader/debug port. The CPU normally has priority; a starvation counter guarantees the loader a grant within a bounded wait. A lock input lets the loader hold the RAM for a bounded burst. The block sits between the memory stage and the RAM, and its stall output feeds the hazard unit.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, maximum consecutive denied loader cycles before a forced loader grant (≥0)
- MAX_BURST, 8, maximum consecutive locked loader grants (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- cpu_req  in  1  memory stage needs the RAM this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU owns the RAM this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rdata  out  DW  ram_rdata passed through, valid when cpu_gnt
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write enable
- ldr_lock  in  1  loader requests burst ownership
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_gnt  out  1  loader owns the RAM this cycle
- ldr_rvalid  out  1  ldr_rdata valid, one cycle after a loader read grant
- ldr_rdata  out  DW  registered loader read data
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data

## Operation
- State register holds two states:
  - IDLE: CPU priority.
  - BURST: loader priority.
- Registered counters:
  - wait_cnt: saturates at MAX_WAIT.
  - burst_cnt: counts 0..MAX_BURST.
- Forced grant condition: force = ldr_req & (wait_cnt == MAX_WAIT).
- Grant rules in IDLE, evaluated in this order:
  - force → ldr_gnt
  - else cpu_req → cpu_gnt
  - else ldr_req → ldr_gnt
  - else no grant
- Grant rule in BURST: ldr_req → ldr_gnt; otherwise cpu_req → cpu_gnt.
- At most one grant per cycle. cpu_gnt and ldr_gnt are never both 1.
- RAM mux:
  - Granted port drives ram_addr/ram_wdata, and ram_we = that port's we.
  - With no grant, ram_we=0, ram_addr=0, ram_wdata=0.
- wait_cnt:
  - Increments (saturating) when ldr_req & ~ldr_gnt.
  - Clears when ldr_gnt or ~ldr_req.
- IDLE→BURST on ldr_gnt & ldr_lock. burst_cnt is set to 1 on entry.
- In BURST, each ldr_gnt increments burst_cnt.
- BURST→IDLE when, at the clock edge:
  - ~ldr_req, or
  - ~ldr_lock, or
  - burst_cnt == MAX_BURST after the increment.
  - On exit, burst_cnt clears.
- After a MAX_BURST exit, the following cycle is IDLE with wait_cnt=0, so a waiting CPU wins.
- ldr_rdata captures ram_rdata on any edge ending a cycle with ldr_gnt & ~ldr_we. ldr_rvalid is the registered value of that condition.
- MAX_WAIT=0: any loader request is forced, so the loader has strict priority.

## Timing
- cpu_gnt, ldr_gnt, cpu_stall and the RAM mux are combinational from registered state and current inputs: zero-cycle grant.
- Writes commit at the rising edge that ends the grant cycle.
- CPU read data is combinational in the grant cycle and is captured by the downstream pipeline register.
- Loader read latency is 1 cycle. ldr_rvalid is a single-cycle pulse per read grant; back-to-back reads give back-to-back pulses.
- Reset values:
  - state=IDLE, wait_cnt=0, burst_cnt=0, ldr_rvalid=0, ldr_rdata=0.
  - While rst=1, all grants=0, ram_we=0, cpu_stall=cpu_req.
- Reset mid-burst aborts immediately (asynchronous). Any pending ldr_rvalid is dropped.
- Simultaneous cpu_req & ldr_req with wait_cnt<MAX_WAIT in IDLE: CPU wins, wait_cnt increments.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BURST)
  - default values of MAX_WAIT and MAX_BURST
- One sub-module, arb_sat_counter: a parameterized saturating counter with clear, increment and load inputs. It is instantiated for wait_cnt and burst_cnt.
- The RAM itself stays outside; dmem_arbiter only drives its port.

## Test plan
- CPU-only writes and reads:
  - cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF; then a read of 0x10 → cpu_gnt=1 both cycles, cpu_stall=0, cpu_rdata=0xDEADBEEF in the read cycle.
- Starvation bound:
  - cpu_req and ldr_req held high with MAX_WAIT=4 → ldr_gnt is asserted in cycle 5 only, cpu_stall=1 in that cycle only.
  - Repeats every 5 cycles.
- Loader read latency:
  - Loader reads 0x20 (holding 0x12345678) with the CPU idle → ldr_gnt in cycle N; ldr_rvalid=1 and ldr_rdata=0x12345678 in cycle N+1.
- Burst cap:
  - ldr_lock=1, ldr_req held high, cpu_req high, MAX_BURST=8 → exactly 8 consecutive ldr_gnt, then cpu_gnt=1 the next cycle.
- Early burst exit:
  - ldr_lock dropped after 3 grants, with cpu_req high → cpu_gnt on the next cycle, state=IDLE.
- Reset mid-burst:
  - rst asserted during a locked loader read → grants and ram_we drop to 0 immediately, and ldr_rvalid=0.
  - After release, state=IDLE, and the CPU is granted first on simultaneous requests.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Holds the arbiter state enum and counter width helper.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_WAIT_DEF  = 4;
  localparam int unsigned MAX_BURST_DEF = 8;

  // Bits needed to hold 0..max, never less than one.
  function automatic int unsigned cnt_w(
    input int unsigned max
  );
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear, load and increment.
// Priority: clear, then load, then increment.
module arb_sat_counter #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU priority, bounded loader starvation,
// and locked loader bursts capped at MAX_BURST grants.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned WW = cnt_w(MAX_WAIT);
  localparam int unsigned BW = cnt_w(MAX_BURST);

  localparam logic [WW-1:0] L_WMAX  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] L_BLAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] L_BONE  = BW'(1);
  // A one-grant burst cap means the entry grant already ends it.
  localparam logic L_CAN_BURST = (MAX_BURST > 1);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [WW-1:0] w_wait_cnt;
  logic [BW-1:0] w_burst_cnt;
  logic          w_force;
  logic          w_cpu_gnt;
  logic          w_ldr_gnt;
  logic          w_enter;
  logic          w_exit;
  logic          w_ldr_rd;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  assign w_force = ldr_req & (w_wait_cnt == L_WMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_enter = (r_state == ARB_IDLE) & w_ldr_gnt
                 & ldr_lock & L_CAN_BURST;
  assign w_exit  = (r_state == ARB_BURST)
                 & (~ldr_req | ~ldr_lock
                 | (w_ldr_gnt & (w_burst_cnt == L_BLAST)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE:  if (w_enter) w_next = ARB_BURST;
      ARB_BURST: if (w_exit)  w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  // Grants are gated by reset so the RAM is released immediately.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_force)      w_ldr_gnt = 1'b1;
          else if (cpu_req) w_cpu_gnt = 1'b1;
          else if (ldr_req) w_ldr_gnt = 1'b1;
        end
        ARB_BURST: begin
          if (ldr_req)      w_ldr_gnt = 1'b1;
          else if (cpu_req) w_cpu_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (w_ldr_gnt) begin
      ram_we    = ldr_we;
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign ldr_gnt   = w_ldr_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign cpu_rdata = ram_rdata;

  arb_sat_counter #(
    .W   (WW),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_ldr_gnt | ~ldr_req),
    .i_inc      (ldr_req & ~w_ldr_gnt),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (w_wait_cnt)
  );

  arb_sat_counter #(
    .W   (BW),
    .MAX (MAX_BURST)
  ) u_burst_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_exit),
    .i_inc      ((r_state == ARB_BURST) & w_ldr_gnt),
    .i_load     (w_enter),
    .i_load_val (L_BONE),
    .o_cnt      (w_burst_cnt)
  );

  assign w_ldr_rd = w_ldr_gnt & ~ldr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_ldr_rd;
      if (w_ldr_rd) r_rdata <= ram_rdata;
    end
  end

  assign ldr_rvalid = r_rvalid;
  assign ldr_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter.
// Stimulus queues per-cycle expectations; a monitor checks them.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ldr_req, ldr_we, ldr_lock;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [256];

  dmem_arbiter #(
    .AW        (32),
    .DW        (32),
    .MAX_WAIT  (4),
    .MAX_BURST (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_lock   (ldr_lock),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial forever #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
  end

  typedef struct {
    string       nm;
    logic        cg;
    logic        lg;
    logic        st;
    logic        we;
    logic [31:0] addr;
    logic        rv;
    logic [31:0] rd;
    logic        chk_c;
    logic [31:0] crd;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".cpu_gnt"}, 32'(cpu_gnt), 32'(e.cg));
      chk({e.nm, ".ldr_gnt"}, 32'(ldr_gnt), 32'(e.lg));
      chk({e.nm, ".stall"}, 32'(cpu_stall), 32'(e.st));
      chk({e.nm, ".ram_we"}, 32'(ram_we), 32'(e.we));
      chk({e.nm, ".ram_addr"}, ram_addr, e.addr);
      chk({e.nm, ".rvalid"}, 32'(ldr_rvalid), 32'(e.rv));
      if (e.rv) chk({e.nm, ".ldr_rdata"}, ldr_rdata, e.rd);
      if (e.chk_c) chk({e.nm, ".cpu_rdata"}, cpu_rdata, e.crd);
    end
  end

  task automatic drv_cpu(input logic r, input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d);
    cpu_req   = r;
    cpu_we    = w;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic drv_ldr(input logic r, input logic w,
                         input logic k,
                         input logic [31:0] a,
                         input logic [31:0] d);
    ldr_req   = r;
    ldr_we    = w;
    ldr_lock  = k;
    ldr_addr  = a;
    ldr_wdata = d;
  endtask

  task automatic cyc(input string nm,
                     input logic cg, input logic lg,
                     input logic we,
                     input logic [31:0] addr,
                     input logic rv,
                     input logic [31:0] rd,
                     input logic chk_c,
                     input logic [31:0] crd);
    exp_t e;
    e.nm    = nm;
    e.cg    = cg;
    e.lg    = lg;
    e.st    = cpu_req & ~cg;
    e.we    = we;
    e.addr  = addr;
    e.rv    = rv;
    e.rd    = rd;
    e.chk_c = chk_c;
    e.crd   = crd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    drv_cpu(0, 0, 0, 0);
    drv_ldr(0, 0, 0, 0, 0);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] PAT = 32'h1234_5678;

  initial begin
    drv_cpu(1, 0, 0, 0);
    drv_ldr(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    drv_cpu(0, 0, 0, 0);
    drv_ldr(1, 1, 0, 32'h20, PAT);
    cyc("ldr_wr", 0, 1, 1, 32'h20, 0, 0, 0, 0);

    drv_ldr(0, 0, 0, 0, 0);
    drv_cpu(1, 1, 32'h10, 32'hDEAD_BEEF);
    cyc("cpu_wr", 1, 0, 1, 32'h10, 0, 0, 0, 0);
    drv_cpu(1, 0, 32'h10, 0);
    cyc("cpu_rd", 1, 0, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF);

    drv_cpu(0, 0, 0, 0);
    drv_ldr(1, 0, 0, 32'h20, 0);
    cyc("ldr_rd", 0, 1, 0, 32'h20, 0, 0, 0, 0);
    drv_ldr(0, 0, 0, 0, 0);
    cyc("ldr_rv", 0, 0, 0, 0, 1, PAT, 0, 0);

    drv_cpu(1, 0, 32'h40, 0);
    drv_ldr(1, 1, 0, 32'h30, 32'hAA);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++)
        cyc("starve_cpu", 1, 0, 0, 32'h40, 0, 0, 0, 0);
      cyc("starve_ldr", 0, 1, 1, 32'h30, 0, 0, 0, 0);
    end
    idle("idle1");

    drv_cpu(1, 0, 32'h40, 0);
    drv_ldr(1, 0, 1, 32'h20, 0);
    for (int i = 0; i < 4; i++)
      cyc("cap_cpu", 1, 0, 0, 32'h40, 0, 0, 0, 0);
    cyc("cap_ldr0", 0, 1, 0, 32'h20, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      cyc("cap_ldr", 0, 1, 0, 32'h20, 1, PAT, 0, 0);
    cyc("cap_cpu_after", 1, 0, 0, 32'h40, 1, PAT, 0, 0);
    idle("idle2");

    drv_ldr(1, 1, 1, 32'h50, 32'h11);
    cyc("ee_ldr0", 0, 1, 1, 32'h50, 0, 0, 0, 0);
    drv_cpu(1, 0, 32'h40, 0);
    cyc("ee_ldr1", 0, 1, 1, 32'h50, 0, 0, 0, 0);
    cyc("ee_ldr2", 0, 1, 1, 32'h50, 0, 0, 0, 0);
    drv_ldr(1, 1, 0, 32'h50, 32'h11);
    cyc("ee_unlock", 0, 1, 1, 32'h50, 0, 0, 0, 0);
    cyc("ee_cpu", 1, 0, 0, 32'h40, 0, 0, 0, 0);
    idle("idle3");

    drv_ldr(1, 0, 1, 32'h20, 0);
    cyc("rb_ldr0", 0, 1, 0, 32'h20, 0, 0, 0, 0);
    drv_cpu(1, 0, 32'h40, 0);
    cyc("rb_ldr1", 0, 1, 0, 32'h20, 1, PAT, 0, 0);
    rst = 1'b1;
    cyc("rb_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("rb_cpu", 1, 0, 0, 32'h40, 0, 0, 0, 0);
    idle("idle4");

    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
